// File: rtl/antares_seq_divider.sv
// Iterative radix-2 restoring divider (signed/unsigned) with a start/stall handshake.
// Optional macro ANTARES_DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module antares_seq_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_divs,
    input  logic                  op_divu,
    input  logic                  op_abort,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_stall
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state;
    logic [CW-1:0]         counter;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] div_reg;
    // Partial remainder is always below the divisor, so W bits suffice;
    // the 33rd bit of each step only exists transiently in rem_sh.
    logic [DATA_WIDTH-1:0] rem;
    logic                  neg_q;
    logic                  neg_r;

    logic                  start;
    logic                  is_signed;
    logic [DATA_WIDTH-1:0] mag_a;
    logic [DATA_WIDTH-1:0] mag_b;
    logic [DATA_WIDTH:0]   rem_sh;
    logic                  sub_ok;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quo_next;
    logic                  step_en;

`ifdef ANTARES_DIV_EARLY_EXIT_EN
    logic skip;
    logic early;
`endif

    // An abort in the same cycle as a start suppresses the start; signed wins a tie.
    assign start     = (op_divs | op_divu) & ~op_abort;
    assign is_signed = op_divs;
    assign mag_a     = (is_signed && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
    assign mag_b     = (is_signed && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;

    assign rem_sh   = {rem, quo[DATA_WIDTH-1]};
    assign sub_ok   = (rem_sh >= {1'b0, div_reg});
    assign rem_next = sub_ok ? (rem_sh[DATA_WIDTH-1:0] - div_reg) : rem_sh[DATA_WIDTH-1:0];
    assign quo_next = {quo[DATA_WIDTH-2:0], sub_ok};

`ifdef ANTARES_DIV_EARLY_EXIT_EN
    assign early   = (mag_b != '0) && (mag_a < mag_b);
    assign step_en = ~skip;
`else
    assign step_en = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
            quo     <= '0;
            div_reg <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`ifdef ANTARES_DIV_EARLY_EXIT_EN
            skip    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo     <= mag_a;
                        div_reg <= mag_b;
                        rem     <= '0;
                        neg_q   <= is_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                        neg_r   <= is_signed & dividend[DATA_WIDTH-1];
                        counter <= CW'(DATA_WIDTH);
                        state   <= BUSY;
`ifdef ANTARES_DIV_EARLY_EXIT_EN
                        skip    <= early;
                        if (early) begin
                            quo     <= '0;
                            rem     <= mag_a;
                            counter <= CW'(1);
                        end
`endif
                    end
                end
                BUSY: begin
                    if (op_abort) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else begin
                        if (step_en) begin
                            quo <= quo_next;
                            rem <= rem_next;
                        end
                        counter <= counter - CW'(1);
                        if (counter == CW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_stall = (state == BUSY);
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;

endmodule

// File: tb/tb_antares_seq_divider.sv
// Self-checking bench for antares_seq_divider: table-driven vectors with a result
// scoreboard, plus hand-written ignore/abort/reset sequences.
module tb_antares_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_divs;
    logic        op_divu;
    logic        op_abort;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_stall;

    int checks   = 0;
    int failures = 0;

`ifdef ANTARES_DIV_EARLY_EXIT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    typedef struct {
        logic        sgn;
        logic        both;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    res_t sb[$];
    vec_t vecs[12];

    antares_seq_divider #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_divs   (op_divs),
        .op_divu   (op_divu),
        .op_abort  (op_abort),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .div_stall (div_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_cycles(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sgn && a[31]) ? (~a + 32'd1) : a;
        mb = (sgn && b[31]) ? (~b + 32'd1) : b;
        return (EARLY_EN && mb != 32'd0 && ma < mb) ? 1 : 32;
    endfunction

    // Drive a one-cycle start pulse; returns just after the sampling edge T.
    task automatic start_op(input logic sgn, input logic both, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        op_divs  = sgn;
        op_divu  = ~sgn | both;
        @(posedge clk);
        #1;
        op_divs  = 1'b0;
        op_divu  = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] q, input logic [31:0] r);
        res_t e;
        e.q = q;
        e.r = r;
        sb.push_back(e);
    endtask

    // Count samples with div_stall high; bounded so a stuck DUT still terminates.
    task automatic wait_done(output int n);
        n = 0;
        while (div_stall === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_result(input string name);
        res_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got q=0x%08h r=0x%08h", name, quotient, remainder);
        end else begin
            e = sb.pop_front();
            check({name, "_q"}, quotient, e.q);
            check({name, "_r"}, remainder, e.r);
        end
    endtask

    initial begin
        int n;
        int pre;

        vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
        vecs[2]  = '{1'b1, 1'b0, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2};
        vecs[3]  = '{1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[4]  = '{1'b0, 1'b0, 32'd7,          32'd0,          32'hFFFFFFFF,   32'd7};
        vecs[5]  = '{1'b0, 1'b0, 32'd5,          32'd9,          32'd0,          32'd5};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFF9,   32'd0,          32'd1,          32'hFFFFFFF9};
        vecs[7]  = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
        vecs[10] = '{1'b0, 1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFB,   32'd9,          32'd0,          32'hFFFFFFFB};

        rst      = 1'b0;
        op_divs  = 1'b0;
        op_divu  = 1'b0;
        op_abort = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("reset_stall", {31'd0, div_stall}, 32'd0);
        check("reset_q", quotient, 32'd0);
        check("reset_r", remainder, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].sgn, vecs[i].both, vecs[i].a, vecs[i].b);
            push_exp(vecs[i].q, vecs[i].r);
            wait_done(n);
            check($sformatf("vec%0d_cycles", i), 32'(n), 32'(exp_cycles(vecs[i].sgn, vecs[i].a, vecs[i].b)));
            expect_result($sformatf("vec%0d", i));
        end

        // Start pulse while busy is ignored and operands are not re-sampled.
        start_op(1'b0, 1'b0, 32'd100, 32'd7);
        push_exp(32'd14, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        op_divu  = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        op_divu = 1'b0;
        wait_done(n);
        check("ignore_cycles", 32'(5 + n), 32'd32);
        expect_result("ignore");

        // Abort at T+10, then a fresh start at T+12.
        start_op(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("abort_pre_stall", {31'd0, div_stall}, 32'd1);
        op_abort = 1'b1;
        @(posedge clk);
        #1;
        op_abort = 1'b0;
        check("abort_stall", {31'd0, div_stall}, 32'd0);
        start_op(1'b0, 1'b0, 32'd9, 32'd3);
        push_exp(32'd3, 32'd0);
        wait_done(n);
        check("after_abort_cycles", 32'(n), 32'd32);
        expect_result("after_abort");

        // Abort together with a start in IDLE suppresses the start.
        @(posedge clk);
        #1;
        op_divu  = 1'b1;
        op_abort = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        op_divu  = 1'b0;
        op_abort = 1'b0;
        check("idle_abort_stall", {31'd0, div_stall}, 32'd0);
        check("idle_abort_q", quotient, 32'd3);

        // Asynchronous reset mid-operation clears everything immediately.
        start_op(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #2;
        pre = int'(div_stall);
        check("rst_pre_stall", 32'(pre), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_stall", {31'd0, div_stall}, 32'd0);
        check("post_rst_q", quotient, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/antares_seq_divider.md
Name: antares_seq_divider

Overview:
- Iterative radix-2 restoring divider; the responder end of the ALU's divide-start/stall handshake.
- Accepts a one-cycle start pulse (signed or unsigned), holds div_stall high while iterating, then presents quotient/remainder for the ALU to latch into HILO.
- Sits inside the execution stage as the hardware divider.
- One operation in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- op_divs  in  1  start signed divide, one-cycle pulse.
- op_divu  in  1  start unsigned divide, one-cycle pulse.
- op_abort  in  1  cancel the operation in flight (pipeline flush).
- dividend  in  DATA_WIDTH  sampled on the start cycle only.
- divisor  in  DATA_WIDTH  sampled on the start cycle only.
- quotient  out  DATA_WIDTH  sign-corrected quotient; valid while div_stall=0 after completion.
- remainder  out  DATA_WIDTH  sign-corrected remainder; sign follows the dividend.
- div_stall  out  1  high while an operation is executing.

Behaviour:
- States: IDLE, BUSY. div_stall = (state==BUSY), driven from registers only.
- Reset (rst=0, async): state=IDLE, counter=0, all internal registers and outputs zero, div_stall=0.
- Start: in IDLE, (op_divs|op_divu) sampled at edge T →
  - Latch |dividend| into the quotient shift register and |divisor| into the divisor register (magnitudes taken only if op_divs).
  - Clear the 33-bit partial remainder.
  - Latch neg_q = signed & (a[31]^b[31]) and neg_r = signed & a[31].
  - counter=DATA_WIDTH; state=BUSY.
- If op_divs and op_divu are both high, op_divs wins.
- Start pulses while BUSY are ignored; operands are not re-sampled.
- Each BUSY cycle performs one iteration:
  - Shift {rem, quo} left 1.
  - trial = rem - div (33-bit).
  - If trial >= 0: rem=trial, quo[0]=1; else quo[0]=0.
  - counter decrements.
- The iteration with counter==1 returns the state to IDLE.
- Latency: div_stall high in cycles T+1..T+DATA_WIDTH (32 cycles); low at T+33 with results valid.
- Outputs (combinational from registers):
  - quotient = neg_q ? -quo : quo.
  - remainder = neg_r ? -rem[31:0] : rem[31:0].
  - Results hold until the next accepted start.
- Divide by zero is not trapped. The algorithm result is produced:
  - Unsigned: quotient = all-ones, remainder = dividend.
  - Signed: the same, with sign correction applied.
- Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. No flag.
- op_abort:
  - In BUSY: state goes to IDLE on the next edge and div_stall drops. Output registers keep partial garbage and must not be consumed.
  - In IDLE: no effect.
  - If op_abort and a start arrive in the same IDLE cycle, the start is suppressed.
- Reset asserted mid-operation: immediate return to IDLE with all registers zero.

Optional Feature:
- Macro: ANTARES_DIV_EARLY_EXIT_EN.
- With the macro defined:
  - At start, if |dividend| < |divisor| (unsigned magnitude compare, divisor != 0), load quo=0 and rem=|dividend|, and set counter=1 with the iteration step bypassed.
  - div_stall is high for exactly one cycle (T+1); results are valid at T+2.
- Without the macro: every operation takes DATA_WIDTH cycles, including this case.

Test Plan:
- Unsigned 100/7: pulse op_divu → div_stall high exactly 32 cycles; then quotient=14 (0x0E), remainder=2.
- Signed -100/7 (0xFFFFFF9C / 0x7): op_divs → after 32 cycles quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Signed 100/-7 → quotient=0xFFFFFFF2, remainder=2.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 7/0 → quotient=0xFFFFFFFF, remainder=7.
- Start 100/7, then pulse op_divu with 9/3 at cycle T+5 → ignored; results still 14/2 at T+33. Repeat with op_abort at T+10 → div_stall low at T+11; a new start at T+12 of 9/3 gives quotient=3, remainder=0.
- Drive rst=0 at T+15 mid-operation (asynchronous, between edges) → div_stall, quotient and remainder go to 0 immediately; no resumption after release.
- Unsigned 5/9: with ANTARES_DIV_EARLY_EXIT_EN, div_stall high 1 cycle; without it, 32 cycles. Both give quotient=0, remainder=5.
